// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-through bypass
// and a per-register pending scoreboard for long-latency results.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic            issue_long,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  output logic [NREG-1:0] pending
);

  logic [NREG-1:1][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:1]           pend_q, pend_d;

  logic [XLEN-1:0] r1, r2;
  logic            hit1, hit2, hitd;
  logic            p1, p2, pd;
  logic            byp1, byp2, bypd;
  logic            raw1, raw2, waw;
  logic            set_en;

  // Look up storage and pending bits; x0 and out-of-range never hit.
  always_comb begin
    r1   = '0;
    r2   = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    hitd = 1'b0;
    p1   = 1'b0;
    p2   = 1'b0;
    pd   = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (rs1_addr == AW'(i)) begin
        r1   = regs_q[i];
        p1   = pend_q[i];
        hit1 = 1'b1;
      end
      if (rs2_addr == AW'(i)) begin
        r2   = regs_q[i];
        p2   = pend_q[i];
        hit2 = 1'b1;
      end
      if (issue_rd == AW'(i)) begin
        pd   = pend_q[i];
        hitd = 1'b1;
      end
    end
  end

  // Bypass, hazard detection and operand selection.
  always_comb begin
    byp1   = we && (wa == rs1_addr) && hit1;
    byp2   = we && (wa == rs2_addr) && hit2;
    bypd   = we && (wa == issue_rd) && hitd;
    raw1   = rs1_used && p1 && !byp1;
    raw2   = rs2_used && p2 && !byp2;
    waw    = issue_valid && issue_long && pd && !bypd;
    stall  = raw1 | raw2 | waw;
    set_en = issue_valid && issue_long && !stall;
    rs1_data = '0;
    rs2_data = '0;
    if (rst_n && hit1) rs1_data = byp1 ? wd : r1;
    if (rst_n && hit2) rs2_data = byp2 ? wd : r2;
    pending = {pend_q, 1'b0};
  end

  // Next state: writeback clears pending, a new long issue sets it
  // and wins because the writeback belongs to an older instruction.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (we && wa == AW'(i)) begin
        regs_d[i] = wd;
        pend_d[i] = 1'b0;
      end
      if (set_en && issue_rd == AW'(i)) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

endmodule
